// File: rtl/btn_capture_pkg.sv
// Shared definitions for the push-button request capture block.
//   NUM_BTN         number of button lines handled
//   cap_state_t     presenter FSM state encoding
//   highest_onehot  one-hot of the highest-index set bit (bit 3 wins)
package btn_capture_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } cap_state_t;

  function automatic logic [NUM_BTN-1:0] highest_onehot(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] r;
    r = '0;
    // Later iterations overwrite earlier ones, so the highest set index wins.
    for (int i = 0; i < NUM_BTN; i++) begin
      if (req[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button line: two-flop synchroniser followed by a mismatch-run debouncer.
// The debounced level flips once the synchronised value has disagreed with it
// on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   raw    raw button line, asynchronous to clk
//   level  debounced level (registered)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This mismatch would bring the count to DEBOUNCE_CYCLES: flip now.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_request_capture.sv
// Button request capture front-end for the 4-to-2 encoder. Each raw button is
// synchronised and debounced; debounced rising edges latch pending requests,
// which are presented one at a time (highest index first) as a one-hot code
// with a valid/ack handshake and a mandatory one-cycle all-zero gap.
// Optional feature macro: BTN_OVERRUN_EN adds the overrun output.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   btn      raw button lines, active-high, asynchronous
//   qout     one-hot request to encoder din, zero when nothing presented
//   valid    high while qout holds a request
//   ack      consumer accepted the presented request (sampled in HOLD only)
//   overrun  (BTN_OVERRUN_EN) one-cycle pulse when a press hits an already
//            pending line and is lost
//
// state | meaning
// IDLE  | nothing presented; load highest pending request if any
// HOLD  | request presented on qout with valid=1, waiting for ack
// GAP   | one cycle of qout=0 between presented codes
module button_request_capture
  import btn_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] qout,
  output logic               valid,
  input  logic               ack
`ifdef BTN_OVERRUN_EN
  ,
  output logic               overrun
`endif
);

  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] deb_prev;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] sel;
  logic [NUM_BTN-1:0] clr;
  logic [NUM_BTN-1:0] qout_next;
  logic               valid_next;
  cap_state_t         state;
  cap_state_t         state_next;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[i]),
      .level(deb[i])
    );
  end

  assign rise = deb & ~deb_prev;
  assign sel  = highest_onehot(pending);

  // A rise arriving on the same edge a bit is cleared keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_prev <= '0;
      pending  <= '0;
    end else begin
      deb_prev <= deb;
      pending  <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      qout  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      qout  <= qout_next;
      valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    clr        = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_next = HOLD;
          clr        = sel;
        end
      end
      HOLD: begin
        if (ack) state_next = GAP;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values are computed for the next state so qout/valid are flops.
  always_comb begin
    qout_next  = '0;
    valid_next = 1'b0;
    if (state_next == HOLD) begin
      valid_next = 1'b1;
      qout_next  = (state == IDLE) ? sel : qout;
    end
  end

`ifdef BTN_OVERRUN_EN
  // A press on a line that stays pending is lost; one being cleared this
  // edge is not, because set-wins keeps the new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= |(rise & pending & ~clr);
  end
`endif

endmodule
